// File: rtl/sc_datapath.sv
// sc_datapath: register bank, bus muxes, ALU and shift register driven by SC_STATEMACHINE control words.
// Optional DATAPATH_SATURATION_EN clamps ADD/INC/SUB/DEC results on carry/borrow instead of wrapping.
module sc_datapath #(
  parameter int DATAWIDTH_BUS                  = 8,
  parameter int DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int REGFIX0_VALUE                  = 0,
  parameter int REGFIX1_VALUE                  = 1
) (
  input  logic                                      SC_DATAPATH_CLOCK_50,
  input  logic                                      SC_DATAPATH_RESET_InLow,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DATAPATH_decoderclearselection_InBUS,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DATAPATH_decoderloadselection_InBUS,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_muxselectionBUSA_InBUS,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_muxselectionBUSB_InBUS,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_DATAPATH_aluselection_InBUS,
  input  logic                                      SC_DATAPATH_regSHIFTERclear_InLow,
  input  logic                                      SC_DATAPATH_regSHIFTERload_InLow,
  input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_DATAPATH_regSHIFTERshiftselection_InLow,
  output logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_BUSC_OutBUS,
  output logic                                      SC_DATAPATH_overflow_OutLow,
  output logic                                      SC_DATAPATH_carry_OutLow,
  output logic                                      SC_DATAPATH_negative_OutLow,
  output logic                                      SC_DATAPATH_zero_OutLow
);

  localparam int W  = DATAWIDTH_BUS;
  localparam int DW = DATAWIDTH_DECODER_SELECTION;
  localparam int MW = DATAWIDTH_MUX_SELECTION;
  localparam int AW = DATAWIDTH_ALU_SELECTION;
  localparam int SW = DATAWIDTH_REGSHIFTER_SELECTION;

  localparam logic [W-1:0] FIX0 = W'(REGFIX0_VALUE);
  localparam logic [W-1:0] FIX1 = W'(REGFIX1_VALUE);
  localparam logic [W-1:0] ONE  = W'(1);

  localparam logic [AW-1:0] OP_OR  = AW'(1);
  localparam logic [AW-1:0] OP_AND = AW'(2);
  localparam logic [AW-1:0] OP_NOT = AW'(3);
  localparam logic [AW-1:0] OP_XOR = AW'(4);
  localparam logic [AW-1:0] OP_ADD = AW'(8);
  localparam logic [AW-1:0] OP_SUB = AW'(9);
  localparam logic [AW-1:0] OP_INC = AW'(10);
  localparam logic [AW-1:0] OP_DEC = AW'(11);

  localparam logic [SW-1:0] SH_LEFT  = SW'(1);
  localparam logic [SW-1:0] SH_RIGHT = SW'(2);

  logic [W-1:0] reg_gen [4];
  logic [W-1:0] bus_a;
  logic [W-1:0] bus_b;
  logic [W-1:0] addend;
  logic [W:0]   ext;
  logic [W-1:0] alu_raw;
  logic [W-1:0] alu_result;
  logic         alu_carry;
  logic         alu_ovf;
  logic [W-1:0] shl_val;
  logic [W-1:0] shr_val;

  logic [W-1:0] busc_p1;
  logic         ovf_n_p1;
  logic         carry_n_p1;
  logic         neg_n_p1;
  logic         zero_n_p1;

  function automatic logic [W-1:0] bus_select(input logic [MW-1:0] sel,
                                               input logic [W-1:0] g0, g1, g2, g3);
    logic [W-1:0] v;
    v = '0;
    if (sel == MW'(0))      v = g0;
    else if (sel == MW'(1)) v = g1;
    else if (sel == MW'(2)) v = g2;
    else if (sel == MW'(3)) v = g3;
    else if (sel == MW'(4)) v = FIX0;
    else if (sel == MW'(5)) v = FIX1;
    return v;
  endfunction

  function automatic logic add_overflow(input logic signed [W-1:0] a, b, r);
    return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
  endfunction

  function automatic logic sub_overflow(input logic signed [W-1:0] a, b, r);
    return ((a < 0) != (b < 0)) && ((r < 0) != (a < 0));
  endfunction

`ifdef DATAPATH_SATURATION_EN
  // Carry on an add clamps high, borrow on a subtract clamps low.
  function automatic logic [W-1:0] saturate(input logic [W-1:0] r, input logic c,
                                            input logic [AW-1:0] op);
    logic [W-1:0] v;
    v = r;
    if (c && (op == OP_ADD || op == OP_INC)) v = '1;
    if (c && (op == OP_SUB || op == OP_DEC)) v = '0;
    return v;
  endfunction
`endif

  // Stage p0: bus muxes and ALU, purely combinational from the register bank.
  assign bus_a  = bus_select(SC_DATAPATH_muxselectionBUSA_InBUS,
                             reg_gen[0], reg_gen[1], reg_gen[2], reg_gen[3]);
  assign bus_b  = bus_select(SC_DATAPATH_muxselectionBUSB_InBUS,
                             reg_gen[0], reg_gen[1], reg_gen[2], reg_gen[3]);
  assign addend = (SC_DATAPATH_aluselection_InBUS == OP_INC ||
                   SC_DATAPATH_aluselection_InBUS == OP_DEC) ? ONE : bus_b;

  always_comb begin
    alu_raw   = bus_a;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    ext       = '0;
    case (SC_DATAPATH_aluselection_InBUS)
      OP_OR:  alu_raw = bus_a | bus_b;
      OP_AND: alu_raw = bus_a & bus_b;
      OP_NOT: alu_raw = ~bus_a;
      OP_XOR: alu_raw = bus_a ^ bus_b;
      OP_ADD, OP_INC: begin
        ext       = {1'b0, bus_a} + {1'b0, addend};
        alu_raw   = ext[W-1:0];
        alu_carry = ext[W];
        alu_ovf   = add_overflow(bus_a, addend, ext[W-1:0]);
      end
      OP_SUB, OP_DEC: begin
        ext       = {1'b0, bus_a} - {1'b0, addend};
        alu_raw   = ext[W-1:0];
        alu_carry = ext[W];
        alu_ovf   = sub_overflow(bus_a, addend, ext[W-1:0]);
      end
      default: alu_raw = bus_a;
    endcase
  end

`ifdef DATAPATH_SATURATION_EN
  assign alu_result = saturate(alu_raw, alu_carry, SC_DATAPATH_aluselection_InBUS);
`else
  assign alu_result = alu_raw;
`endif

  assign shl_val = {busc_p1[W-2:0], 1'b0};
  assign shr_val = {1'b0, busc_p1[W-1:1]};

  // Stage p1: shifter and active-low flags.
  always_ff @(posedge SC_DATAPATH_CLOCK_50) begin
    if (!SC_DATAPATH_RESET_InLow || !SC_DATAPATH_regSHIFTERclear_InLow) begin
      busc_p1    <= '0;
      ovf_n_p1   <= 1'b1;
      carry_n_p1 <= 1'b1;
      neg_n_p1   <= 1'b1;
      zero_n_p1  <= 1'b0;
    end else if (!SC_DATAPATH_regSHIFTERload_InLow) begin
      busc_p1    <= alu_result;
      ovf_n_p1   <= ~alu_ovf;
      carry_n_p1 <= ~alu_carry;
      neg_n_p1   <= ~alu_result[W-1];
      zero_n_p1  <= (alu_result != '0);
    end else if (SC_DATAPATH_regSHIFTERshiftselection_InLow == SH_LEFT) begin
      busc_p1    <= shl_val;
      ovf_n_p1   <= 1'b1;
      carry_n_p1 <= ~busc_p1[W-1];
      neg_n_p1   <= ~shl_val[W-1];
      zero_n_p1  <= (shl_val != '0);
    end else if (SC_DATAPATH_regSHIFTERshiftselection_InLow == SH_RIGHT) begin
      busc_p1    <= shr_val;
      ovf_n_p1   <= 1'b1;
      carry_n_p1 <= ~busc_p1[0];
      neg_n_p1   <= ~shr_val[W-1];
      zero_n_p1  <= (shr_val != '0);
    end
  end

  // Register bank writes back BUSC as it stood before this edge; clear wins over load.
  always_ff @(posedge SC_DATAPATH_CLOCK_50) begin
    for (int i = 0; i < 4; i++) begin
      if (!SC_DATAPATH_RESET_InLow)
        reg_gen[i] <= '0;
      else if (SC_DATAPATH_decoderclearselection_InBUS == DW'(i))
        reg_gen[i] <= '0;
      else if (SC_DATAPATH_decoderloadselection_InBUS == DW'(i))
        reg_gen[i] <= busc_p1;
    end
  end

  assign SC_DATAPATH_BUSC_OutBUS     = busc_p1;
  assign SC_DATAPATH_overflow_OutLow = ovf_n_p1;
  assign SC_DATAPATH_carry_OutLow    = carry_n_p1;
  assign SC_DATAPATH_negative_OutLow = neg_n_p1;
  assign SC_DATAPATH_zero_OutLow     = zero_n_p1;

endmodule

// File: tb/tb_sc_datapath.sv
// Bench for sc_datapath: three instances with different fixed constants, directed
// scenarios followed by random control words, all compared to an arithmetic model.
module tb_sc_datapath;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] clr_sel, ld_sel, mux_a, mux_b;
  logic [3:0] alu_op;
  logic       sh_clr_n, sh_ld_n;
  logic [1:0] sh_sel;

  logic [7:0] busc [3];
  logic       ovf_n [3], carry_n [3], neg_n [3], zero_n [3];

  int checks = 0;
  int errors = 0;

  // Reference state (true-sense flags)
  logic [7:0] m_gen [3][4];
  logic [7:0] m_busc [3];
  logic       m_v [3], m_c [3], m_n [3], m_z [3];
  int         fixv [3][2] = '{'{0, 1}, '{200, 100}, '{5, 7}};

  always #5 clk = ~clk;

  sc_datapath #(.REGFIX0_VALUE(0), .REGFIX1_VALUE(1)) u0 (
    .SC_DATAPATH_CLOCK_50(clk), .SC_DATAPATH_RESET_InLow(rst_n),
    .SC_DATAPATH_decoderclearselection_InBUS(clr_sel), .SC_DATAPATH_decoderloadselection_InBUS(ld_sel),
    .SC_DATAPATH_muxselectionBUSA_InBUS(mux_a), .SC_DATAPATH_muxselectionBUSB_InBUS(mux_b),
    .SC_DATAPATH_aluselection_InBUS(alu_op), .SC_DATAPATH_regSHIFTERclear_InLow(sh_clr_n),
    .SC_DATAPATH_regSHIFTERload_InLow(sh_ld_n), .SC_DATAPATH_regSHIFTERshiftselection_InLow(sh_sel),
    .SC_DATAPATH_BUSC_OutBUS(busc[0]), .SC_DATAPATH_overflow_OutLow(ovf_n[0]),
    .SC_DATAPATH_carry_OutLow(carry_n[0]), .SC_DATAPATH_negative_OutLow(neg_n[0]),
    .SC_DATAPATH_zero_OutLow(zero_n[0]));

  sc_datapath #(.REGFIX0_VALUE(200), .REGFIX1_VALUE(100)) u1 (
    .SC_DATAPATH_CLOCK_50(clk), .SC_DATAPATH_RESET_InLow(rst_n),
    .SC_DATAPATH_decoderclearselection_InBUS(clr_sel), .SC_DATAPATH_decoderloadselection_InBUS(ld_sel),
    .SC_DATAPATH_muxselectionBUSA_InBUS(mux_a), .SC_DATAPATH_muxselectionBUSB_InBUS(mux_b),
    .SC_DATAPATH_aluselection_InBUS(alu_op), .SC_DATAPATH_regSHIFTERclear_InLow(sh_clr_n),
    .SC_DATAPATH_regSHIFTERload_InLow(sh_ld_n), .SC_DATAPATH_regSHIFTERshiftselection_InLow(sh_sel),
    .SC_DATAPATH_BUSC_OutBUS(busc[1]), .SC_DATAPATH_overflow_OutLow(ovf_n[1]),
    .SC_DATAPATH_carry_OutLow(carry_n[1]), .SC_DATAPATH_negative_OutLow(neg_n[1]),
    .SC_DATAPATH_zero_OutLow(zero_n[1]));

  sc_datapath #(.REGFIX0_VALUE(5), .REGFIX1_VALUE(7)) u2 (
    .SC_DATAPATH_CLOCK_50(clk), .SC_DATAPATH_RESET_InLow(rst_n),
    .SC_DATAPATH_decoderclearselection_InBUS(clr_sel), .SC_DATAPATH_decoderloadselection_InBUS(ld_sel),
    .SC_DATAPATH_muxselectionBUSA_InBUS(mux_a), .SC_DATAPATH_muxselectionBUSB_InBUS(mux_b),
    .SC_DATAPATH_aluselection_InBUS(alu_op), .SC_DATAPATH_regSHIFTERclear_InLow(sh_clr_n),
    .SC_DATAPATH_regSHIFTERload_InLow(sh_ld_n), .SC_DATAPATH_regSHIFTERshiftselection_InLow(sh_sel),
    .SC_DATAPATH_BUSC_OutBUS(busc[2]), .SC_DATAPATH_overflow_OutLow(ovf_n[2]),
    .SC_DATAPATH_carry_OutLow(carry_n[2]), .SC_DATAPATH_negative_OutLow(neg_n[2]),
    .SC_DATAPATH_zero_OutLow(zero_n[2]));

  function automatic logic [7:0] src(input int k, input logic [2:0] s);
    if (s < 3'd4) return m_gen[k][s[1:0]];
    if (s == 3'd4) return 8'(fixv[k][0]);
    if (s == 3'd5) return 8'(fixv[k][1]);
    return 8'd0;
  endfunction

  task automatic alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic c, output logic v);
    int ua, ub, sa, sb, s, ss;
    bit arith;
    ua = a; ub = b;
    sa = (a > 127) ? ua - 256 : ua;
    sb = (b > 127) ? ub - 256 : ub;
    arith = 1'b1; s = 0; ss = 0;
    case (op)
      4'd8:  begin s = ua + ub; ss = sa + sb; end
      4'd9:  begin s = ua - ub; ss = sa - sb; end
      4'd10: begin s = ua + 1;  ss = sa + 1;  end
      4'd11: begin s = ua - 1;  ss = sa - 1;  end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      r = 8'(s & 255);
      c = (s > 255) || (s < 0);
      v = (ss > 127) || (ss < -128);
`ifdef DATAPATH_SATURATION_EN
      if (s > 255) r = 8'd255;
      if (s < 0)   r = 8'd0;
`endif
    end else begin
      c = 1'b0; v = 1'b0;
      case (op)
        4'd1: r = a | b;
        4'd2: r = a & b;
        4'd3: r = ~a;
        4'd4: r = a ^ b;
        default: r = a;
      endcase
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] r, old;
      logic c, v;
      old = m_busc[k];
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) m_gen[k][i] = 8'd0;
        m_busc[k] = 8'd0; m_v[k] = 0; m_c[k] = 0; m_n[k] = 0; m_z[k] = 1;
      end else begin
        alu_ref(alu_op, src(k, mux_a), src(k, mux_b), r, c, v);
        if (!sh_clr_n) begin
          m_busc[k] = 8'd0; m_v[k] = 0; m_c[k] = 0; m_n[k] = 0; m_z[k] = 1;
        end else if (!sh_ld_n) begin
          m_busc[k] = r; m_v[k] = v; m_c[k] = c; m_n[k] = r >= 128; m_z[k] = r == 0;
        end else if (sh_sel == 2'b01 || sh_sel == 2'b10) begin
          m_busc[k] = (sh_sel == 2'b01) ? 8'((old * 2) % 256) : old / 2;
          m_c[k] = (sh_sel == 2'b01) ? old >= 128 : old % 2 == 1;
          m_v[k] = 0; m_n[k] = m_busc[k] >= 128; m_z[k] = m_busc[k] == 0;
        end
        for (int i = 0; i < 4; i++) begin
          if (clr_sel == 3'(i)) m_gen[k][i] = 8'd0;
          else if (ld_sel == 3'(i)) m_gen[k][i] = old;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d busc", k),    busc[k],    m_busc[k]);
      chk($sformatf("u%0d ovf_n", k),   8'(ovf_n[k]),   8'(!m_v[k]));
      chk($sformatf("u%0d carry_n", k), 8'(carry_n[k]), 8'(!m_c[k]));
      chk($sformatf("u%0d neg_n", k),   8'(neg_n[k]),   8'(!m_n[k]));
      chk($sformatf("u%0d zero_n", k),  8'(zero_n[k]),  8'(!m_z[k]));
    end
  endtask

  task automatic step(input logic rn, input logic [2:0] clr, input logic [2:0] ld,
                      input logic [2:0] ma, input logic [2:0] mb, input logic [3:0] op,
                      input logic sc, input logic sl, input logic [1:0] sh);
    rst_n = rn; clr_sel = clr; ld_sel = ld; mux_a = ma; mux_b = mb;
    alu_op = op; sh_clr_n = sc; sh_ld_n = sl; sh_sel = sh;
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    rst_n = 1'b1; clr_sel = 3'd4; ld_sel = 3'd4; mux_a = 3'd0; mux_b = 3'd0;
    alu_op = 4'd0; sh_clr_n = 1'b1; sh_ld_n = 1'b1; sh_sel = 2'b00;
    #2;
    // Reset with arbitrary controls asserted
    step(0, 3'd1, 3'd2, 3'd5, 3'd4, 4'd8, 1, 0, 2'b01);
    chk("reset busc", busc[0], 8'd0);
    chk("reset zero_n", 8'(zero_n[0]), 8'd0);
    chk("reset flags_n", {5'd0, ovf_n[0], carry_n[0], neg_n[0]}, 8'd7);

    // ADD RegGEN3 = FIX0 + FIX1
    step(1, 3'd4, 3'd4, 3'd4, 3'd5, 4'd8, 1, 1, 2'b00);
    step(1, 3'd4, 3'd4, 3'd4, 3'd5, 4'd8, 1, 0, 2'b00);
    chk("add busc", busc[0], 8'd1);
    chk("add flags_n", {4'd0, ovf_n[0], carry_n[0], neg_n[0], zero_n[0]}, 8'd15);
`ifdef DATAPATH_SATURATION_EN
    chk("add ovf busc", busc[1], 8'd255);
`else
    chk("add ovf busc", busc[1], 8'd44);
`endif
    chk("add ovf carry_n", 8'(carry_n[1]), 8'd0);
    step(1, 3'd4, 3'd3, 3'd0, 3'd0, 4'd0, 1, 1, 2'b00);
    step(1, 3'd4, 3'd4, 3'd3, 3'd0, 4'd0, 1, 0, 2'b00);
    chk("readback gen3", busc[0], 8'd1);

    // SUB FIX0 - FIX1
    step(1, 3'd4, 3'd4, 3'd4, 3'd5, 4'd9, 1, 0, 2'b00);
`ifdef DATAPATH_SATURATION_EN
    chk("sub busc", busc[2], 8'h00);
    chk("sub neg_n", 8'(neg_n[2]), 8'd1);
`else
    chk("sub busc", busc[2], 8'hFE);
    chk("sub neg_n", 8'(neg_n[2]), 8'd0);
`endif
    chk("sub carry_n", 8'(carry_n[2]), 8'd0);
    chk("sub ovf_n", 8'(ovf_n[2]), 8'd1);

    // Build 0x81 in u0: 1 << 7 into RegGEN0, then INC
    step(1, 3'd4, 3'd4, 3'd5, 3'd0, 4'd0, 1, 0, 2'b00);
    for (int i = 0; i < 7; i++) step(1, 3'd4, 3'd4, 3'd0, 3'd0, 4'd0, 1, 1, 2'b01);
    step(1, 3'd4, 3'd0, 3'd0, 3'd0, 4'd0, 1, 1, 2'b00);
    step(1, 3'd4, 3'd4, 3'd0, 3'd0, 4'd10, 1, 0, 2'b00);
    chk("inc busc", busc[0], 8'h81);
    step(1, 3'd4, 3'd4, 3'd0, 3'd0, 4'd0, 1, 1, 2'b01);
    chk("shl busc", busc[0], 8'h02);
    chk("shl carry_n", 8'(carry_n[0]), 8'd0);
    step(1, 3'd4, 3'd4, 3'd0, 3'd0, 4'd0, 1, 1, 2'b10);
    chk("shr busc", busc[0], 8'h01);
    chk("shr carry_n", 8'(carry_n[0]), 8'd1);

    // Clear beats load on RegGEN2
    step(1, 3'd4, 3'd2, 3'd0, 3'd0, 4'd0, 1, 1, 2'b00);
    step(1, 3'd2, 3'd2, 3'd0, 3'd0, 4'd0, 1, 1, 2'b00);
    step(1, 3'd4, 3'd4, 3'd2, 3'd0, 4'd0, 1, 0, 2'b00);
    chk("clr beats ld gen2", busc[0], 8'd0);
    // Shifter clear beats shifter load
    step(1, 3'd4, 3'd4, 3'd5, 3'd0, 4'd0, 1, 0, 2'b00);
    step(1, 3'd4, 3'd4, 3'd5, 3'd0, 4'd0, 0, 0, 2'b00);
    chk("sh clr beats ld", busc[0], 8'd0);
    chk("sh clr zero_n", 8'(zero_n[0]), 8'd0);
    // Reset during cycle 1 of ADD
    step(1, 3'd4, 3'd4, 3'd4, 3'd5, 4'd8, 1, 1, 2'b00);
    step(0, 3'd4, 3'd4, 3'd4, 3'd5, 4'd8, 1, 0, 2'b00);
    chk("rst mid add busc", busc[0], 8'd0);
    step(1, 3'd4, 3'd3, 3'd0, 3'd0, 4'd0, 1, 1, 2'b00);
    step(1, 3'd4, 3'd4, 3'd3, 3'd0, 4'd0, 1, 0, 2'b00);
    chk("rst mid add gen3", busc[0], 8'd0);

    // Random control words
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_datapath.md
# sc_datapath

Register-bank, ALU and shift-register datapath that executes the control words issued by the SC_STATEMACHINE sequencer. It decodes the sequencer's decoder, mux, ALU and shifter fields. It returns the active-low overflow/carry/negative/zero flags that the sequencer consumes. It exposes BUSC, the shifter output, for display.

## Interface
- DATAWIDTH_BUS, 8: width of every data register and bus.
- DATAWIDTH_DECODER_SELECTION, 3: width of the load and clear decoder fields.
- DATAWIDTH_MUX_SELECTION, 3: width of the BUSA and BUSB select fields.
- DATAWIDTH_ALU_SELECTION, 4: width of the ALU opcode.
- DATAWIDTH_REGSHIFTER_SELECTION, 2: width of the shift select.
- REGFIX0_VALUE, 0: constant held in RegFIX0.
- REGFIX1_VALUE, 1: constant held in RegFIX1.

Ports:
- SC_DATAPATH_CLOCK_50  in  1  sole clock; all state updates on rising edge.
- SC_DATAPATH_RESET_InLow  in  1  **synchronous, active-low reset**.
- SC_DATAPATH_decoderclearselection_InBUS  in  DECODER  000–011 clears RegGEN0–3; 1xx none.
- SC_DATAPATH_decoderloadselection_InBUS  in  DECODER  000–011 loads BUSC into RegGEN0–3; 1xx none.
- SC_DATAPATH_muxselectionBUSA_InBUS  in  MUX  BUSA source.
- SC_DATAPATH_muxselectionBUSB_InBUS  in  MUX  BUSB source.
- SC_DATAPATH_aluselection_InBUS  in  ALU  ALU opcode.
- SC_DATAPATH_regSHIFTERclear_InLow  in  1  0 clears the shifter.
- SC_DATAPATH_regSHIFTERload_InLow  in  1  0 loads the ALU result into the shifter.
- SC_DATAPATH_regSHIFTERshiftselection_InLow  in  SHIFTER  01 shift left; 10 shift right; 00/11 hold.
- SC_DATAPATH_BUSC_OutBUS  out  BUS  shifter contents.
- SC_DATAPATH_overflow_OutLow, SC_DATAPATH_carry_OutLow, SC_DATAPATH_negative_OutLow, SC_DATAPATH_zero_OutLow  out  1 each  registered flags; 0 means the condition is true.

## Operation
- **Bus muxes (combinational):**
  - 000–011 select RegGEN0–3.
  - 100 selects RegFIX0; 101 selects RegFIX1.
  - 110 and 111 drive 0.
- **ALU (combinational) on A=BUSA, B=BUSB:**
  - 0000 A; 0001 A|B; 0010 A&B; 0011 ~A; 0100 A^B.
  - 1000 A+B; 1001 A−B; 1010 A+1; 1011 A−1.
  - 0101–0111 and 1100–1111 pass A.
  - Result is DATAWIDTH_BUS bits, modulo 2^N.
- **Flags computed with the result:**
  - carry: carry-out for 1000/1010; borrow for 1001/1011; false for all other opcodes.
  - overflow: signed overflow for the four arithmetic ops, computed with B=1 for INC/DEC; false otherwise.
  - negative: result MSB.
  - zero: result == 0.
- **Shifter priority, per edge:**
  1. clear=0: shifter ← 0; zero true, others false.
  2. else load=0: shifter ← ALU result; all four flags captured.
  3. else shift 01: shift left, fill 0; carry ← bit shifted out.
  4. else shift 10: shift right, fill 0; carry ← bit shifted out.
  5. else hold.
  - On shifts, negative and zero are recomputed from the new value and overflow is set false.
- **Register bank:**
  - RegGENn ← 0 when the clear decoder selects n.
  - Otherwise RegGENn ← BUSC when the load decoder selects n.
  - Clear beats load on the same register.
  - Clear and load may target different registers in the same cycle.
  - The value loaded is BUSC before that edge's shifter update.
- RegFIX0 and RegFIX1 are constants; they are never written.

## Timing
- **Reset** (RESET_InLow=0 at an edge) takes priority over all controls:
  - RegGEN0–3 = 0; BUSC = 0.
  - zero_OutLow = 0; overflow_OutLow, carry_OutLow, negative_OutLow = 1.
  - Reset asserted mid-sequence discards the in-flight result.
- **ADD sequence, cycle by cycle:**
  - Cycle 0: mux and ALU fields valid.
  - Cycle 1: load=0; BUSC and flags update at the end of cycle 1.
  - Cycle 2: decoder load; RegGEN updates at the end of cycle 2.
  - Three cycles total; the ALU must stay stable through cycle 1.
- Flags are visible one edge after a shifter load, clear or shift, which matches the sequencer's next-state evaluation.
- No handshake: every control word is acted on in the cycle it is presented.

## Configuration
- DATAPATH_SATURATION_EN defined:
  - 1000 and 1010 with carry-out produce all-ones.
  - 1001 and 1011 with borrow produce 0.
  - The carry and overflow flags are still reported.
- DATAPATH_SATURATION_EN undefined: results wrap modulo 2^N.

## Test plan
- **Reset:** hold RESET_InLow=0 for one edge after arbitrary state → RegGEN all 0, BUSC=0, zero_OutLow=0, other flags 1.
- **ADD RegGEN3=RegFIX0+RegFIX1 (defaults 0, 1):** A=100, B=101, ALU=1000; then load=0; then decoder load 011 → BUSC=1 after cycle 1, RegGEN3=1 after cycle 2, all flags 1.
- **Overflow (FIX0=200, FIX1=100):** ADD → BUSC=44, carry_OutLow=0; with DATAPATH_SATURATION_EN → BUSC=255, carry_OutLow=0.
- **Subtract (FIX0=5, FIX1=7):** ALU=1001 → BUSC=0xFE, negative_OutLow=0, carry_OutLow=0 (borrow), overflow_OutLow=1.
- **Shifts:** BUSC=0x81, shift 01 → 0x02 with carry_OutLow=0; then shift 10 → 0x01 with carry_OutLow=1.
- **Collisions:** clear and load both 010 in the same cycle → RegGEN2=0; load=0 with clear=0 → BUSC=0; RESET_InLow=0 during cycle 1 of ADD → BUSC=0 and RegGEN3 unchanged from 0.
